// File: rtl/id_ex_stage_pkg.sv
// Shared definitions for the ID/EX stage: register index width, ALU funct
// codes, and the funct/data values loaded for reset and pipeline bubbles.
package id_ex_stage_pkg;

  localparam int REG_IDX_W = 3;
  localparam int DATA_W    = 16;

  typedef enum logic [3:0] {
    FUNCT_ADD = 4'h0,
    FUNCT_SUB = 4'h1,
    FUNCT_AND = 4'h2,
    FUNCT_OR  = 4'h3,
    FUNCT_XOR = 4'h4,
    FUNCT_SLL = 4'h5,
    FUNCT_SRL = 4'h6,
    FUNCT_SRA = 4'h7,
    FUNCT_SLT = 4'h8
  } funct_e;

  // A bubble executes as "add 0 + 0" with no side effects.
  localparam logic [3:0]        BUBBLE_FUNCT = FUNCT_ADD;
  localparam logic [DATA_W-1:0] BUBBLE_DATA  = '0;

endpackage

// File: rtl/id_ex_stage_if.sv
// Decode/forwarding/EX bundle between the decode stage and the ID/EX
// register. master = upstream decode/pipeline control, slave = id_ex_stage.
interface id_ex_stage_if #(
  parameter int DW = 16,
  parameter int RW = 3
);
  logic          id_valid;
  logic [RW-1:0] id_rs1, id_rs2;
  logic [DW-1:0] id_rs1_val, id_rs2_val;
  logic [DW-1:0] id_imm;
  logic          id_use_imm;
  logic [3:0]    id_funct;
  logic [RW-1:0] id_rd;
  logic          id_reg_write, id_mem_read, id_mem_write, id_branch;
  logic          stall, flush;
  logic          exmem_reg_write;
  logic [RW-1:0] exmem_rd;
  logic [DW-1:0] exmem_result;
  logic          memwb_reg_write;
  logic [RW-1:0] memwb_rd;
  logic [DW-1:0] memwb_result;
  logic [DW-1:0] alu_in1, alu_in2;
  logic [3:0]    alu_op;
  logic [DW-1:0] ex_store_data;
  logic          ex_valid;
  logic [RW-1:0] ex_rd;
  logic          ex_reg_write, ex_mem_read, ex_mem_write, ex_branch;
  logic [DW-1:0] ex_imm;
  logic          load_use_hazard;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rs1_val, id_rs2_val, id_imm, id_use_imm,
           id_funct, id_rd, id_reg_write, id_mem_read, id_mem_write, id_branch,
           stall, flush, exmem_reg_write, exmem_rd, exmem_result,
           memwb_reg_write, memwb_rd, memwb_result,
    input  alu_in1, alu_in2, alu_op, ex_store_data, ex_valid, ex_rd,
           ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_imm,
           load_use_hazard
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rs1_val, id_rs2_val, id_imm, id_use_imm,
           id_funct, id_rd, id_reg_write, id_mem_read, id_mem_write, id_branch,
           stall, flush, exmem_reg_write, exmem_rd, exmem_result,
           memwb_reg_write, memwb_rd, memwb_result,
    output alu_in1, alu_in2, alu_op, ex_store_data, ex_valid, ex_rd,
           ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_imm,
           load_use_hazard
  );
endinterface

// File: rtl/id_ex_stage_fwd_mux.sv
// Operand forwarding selector: EX/MEM result beats MEM/WB result beats the
// registered register-file value. Index 0 (r0) never forwards.
module fwd_mux #(
  parameter int DW = 16,
  parameter int RW = 3
) (
  input  logic [RW-1:0] idx,
  input  logic [DW-1:0] reg_val,
  input  logic          exmem_we,
  input  logic [RW-1:0] exmem_rd,
  input  logic [DW-1:0] exmem_val,
  input  logic          memwb_we,
  input  logic [RW-1:0] memwb_rd,
  input  logic [DW-1:0] memwb_val,
  output logic [DW-1:0] sel_val
);
  logic idx_live;
  assign idx_live = (idx != '0);

  // Priority select of the freshest in-flight value for this operand.
  always_comb begin
    sel_val = reg_val;
    if (idx_live && exmem_we && (exmem_rd == idx))
      sel_val = exmem_val;
    else if (idx_live && memwb_we && (memwb_rd == idx))
      sel_val = memwb_val;
  end
endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register and ALU operand select. Handles stall, flush and
// hazard bubbles. Build option PIPE_FORWARD_EN: when defined, operands are
// forwarded from EX/MEM and MEM/WB and only load-use stalls; when undefined,
// there is no forwarding and any RAW dependency on EX or EX/MEM stalls decode.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int DW = 16,
  parameter int RW = 3
) (
  input logic         clk,
  input logic         rst_n,
  id_ex_stage_if.slave bus
);

  typedef struct packed {
    logic          valid;
    logic [RW-1:0] rs1;
    logic [RW-1:0] rs2;
    logic [DW-1:0] rs1_val;
    logic [DW-1:0] rs2_val;
    logic [DW-1:0] imm;
    logic          use_imm;
    logic [3:0]    funct;
    logic [RW-1:0] rd;
    logic          reg_write;
    logic          mem_read;
    logic          mem_write;
    logic          branch;
    logic          uses_rs2;
  } stage_t;

  stage_t        stage_reg, stage_next, bubble, captured;
  logic          id_uses_rs2;
  logic          hazard_raw;
  logic          fwd_exmem_we, fwd_memwb_we;
  logic [RW-1:0] src_idx [2];
  logic [DW-1:0] src_val [2];
  logic [DW-1:0] fwd_val [2];
  logic          unused_state;

  assign id_uses_rs2  = !bus.id_use_imm | bus.id_mem_write;
  // The registered copy is kept for downstream debug visibility only.
  assign unused_state = stage_reg.uses_rs2;

  // Bubble contents: invalid, no side effects, zero data, ADD.
  always_comb begin
    bubble         = '0;
    bubble.rs1_val = DW'(BUBBLE_DATA);
    bubble.rs2_val = DW'(BUBBLE_DATA);
    bubble.imm     = DW'(BUBBLE_DATA);
    bubble.funct   = BUBBLE_FUNCT;
  end

  // Capture of the decode slot; control bits only survive for a real instruction.
  always_comb begin
    captured           = '0;
    captured.valid     = bus.id_valid;
    captured.rs1       = bus.id_rs1;
    captured.rs2       = bus.id_rs2;
    captured.rs1_val   = bus.id_rs1_val;
    captured.rs2_val   = bus.id_rs2_val;
    captured.imm       = bus.id_imm;
    captured.use_imm   = bus.id_use_imm;
    captured.funct     = bus.id_funct;
    captured.rd        = bus.id_rd;
    captured.reg_write = bus.id_valid & bus.id_reg_write;
    captured.mem_read  = bus.id_valid & bus.id_mem_read;
    captured.mem_write = bus.id_valid & bus.id_mem_write;
    captured.branch    = bus.id_valid & bus.id_branch;
    captured.uses_rs2  = id_uses_rs2;
  end

`ifdef PIPE_FORWARD_EN
  // Only a load in EX can't be forwarded in time; everything else is bypassed.
  always_comb begin
    hazard_raw = stage_reg.valid && stage_reg.mem_read && (stage_reg.rd != '0) &&
                 bus.id_valid &&
                 ((stage_reg.rd == bus.id_rs1) ||
                  ((stage_reg.rd == bus.id_rs2) && id_uses_rs2));
  end
  assign fwd_exmem_we = bus.exmem_reg_write;
  assign fwd_memwb_we = bus.memwb_reg_write;
`else
  // Without bypassing, any pending write in EX or EX/MEM to a decode source
  // stalls; MEM/WB is covered by the write-before-read register file.
  always_comb begin
    hazard_raw = 1'b0;
    if (bus.id_rs1 != '0 &&
        ((stage_reg.valid && stage_reg.reg_write && stage_reg.rd == bus.id_rs1) ||
         (bus.exmem_reg_write && bus.exmem_rd == bus.id_rs1)))
      hazard_raw = 1'b1;
    if (id_uses_rs2 && bus.id_rs2 != '0 &&
        ((stage_reg.valid && stage_reg.reg_write && stage_reg.rd == bus.id_rs2) ||
         (bus.exmem_reg_write && bus.exmem_rd == bus.id_rs2)))
      hazard_raw = 1'b1;
  end
  assign fwd_exmem_we = 1'b0;
  assign fwd_memwb_we = 1'b0;
`endif

  assign bus.load_use_hazard = hazard_raw & !bus.flush;

  // Next-state priority: flush, then stall, then hazard bubble, then capture.
  always_comb begin
    stage_next = captured;
    if (bus.flush)
      stage_next = bubble;
    else if (bus.stall)
      stage_next = stage_reg;
    else if (bus.load_use_hazard)
      stage_next = bubble;
  end

  // Stage register; reset loads the bubble pattern.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_reg       <= '0;
      stage_reg.funct <= BUBBLE_FUNCT;
    end else begin
      stage_reg <= stage_next;
    end
  end

  assign src_idx[0] = stage_reg.rs1;
  assign src_idx[1] = stage_reg.rs2;
  assign src_val[0] = stage_reg.rs1_val;
  assign src_val[1] = stage_reg.rs2_val;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
      fwd_mux #(.DW(DW), .RW(RW)) u_fwd_mux (
        .idx       (src_idx[gi]),
        .reg_val   (src_val[gi]),
        .exmem_we  (fwd_exmem_we),
        .exmem_rd  (bus.exmem_rd),
        .exmem_val (bus.exmem_result),
        .memwb_we  (fwd_memwb_we),
        .memwb_rd  (bus.memwb_rd),
        .memwb_val (bus.memwb_result),
        .sel_val   (fwd_val[gi])
      );
    end
  endgenerate

  assign bus.alu_in1       = fwd_val[0];
  assign bus.ex_store_data = fwd_val[1];
  assign bus.alu_in2       = stage_reg.use_imm ? stage_reg.imm : fwd_val[1];
  assign bus.alu_op        = stage_reg.funct;
  assign bus.ex_valid      = stage_reg.valid;
  assign bus.ex_rd         = stage_reg.rd;
  assign bus.ex_reg_write  = stage_reg.reg_write;
  assign bus.ex_mem_read   = stage_reg.mem_read;
  assign bus.ex_mem_write  = stage_reg.mem_write;
  assign bus.ex_branch     = stage_reg.branch;
  assign bus.ex_imm        = stage_reg.imm;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage. Expected EX bundles are queued when a
// decode slot is driven and compared after the capturing clock edge.
module tb_id_ex_stage;
  import id_ex_stage_pkg::*;

`ifdef PIPE_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  typedef struct packed {
    logic [15:0] in1;
    logic [15:0] in2;
    logic [3:0]  op;
    logic [15:0] store;
    logic [15:0] imm;
    logic        valid;
    logic [2:0]  rd;
    logic        rw, mr, mw, br;
  } obs_t;

  logic clk;
  logic rst_n;
  int   compared;
  int   mismatched;
  obs_t exp_q[$];
  obs_t exp_o, obs;

  id_ex_stage_if #(.DW(16), .RW(3)) bus ();

  id_ex_stage #(.DW(16), .RW(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic obs_t mk(input logic [15:0] in1, in2, input logic [3:0] op,
                              input logic [15:0] store, imm, input logic valid,
                              input logic [2:0] rd, input logic rw, mr, mw, br);
    obs_t o;
    o = '{in1, in2, op, store, imm, valid, rd, rw, mr, mw, br};
    return o;
  endfunction

  function automatic obs_t get_obs();
    obs_t o;
    o = '{bus.alu_in1, bus.alu_in2, bus.alu_op, bus.ex_store_data, bus.ex_imm,
          bus.ex_valid, bus.ex_rd, bus.ex_reg_write, bus.ex_mem_read,
          bus.ex_mem_write, bus.ex_branch};
    return o;
  endfunction

  task automatic drive(input logic v, input logic [2:0] r1, r2,
                       input logic [15:0] d1, d2, im, input logic ui,
                       input logic [3:0] f, input logic [2:0] rd,
                       input logic rw, mr, mw, br);
    bus.id_valid = v;     bus.id_rs1 = r1;     bus.id_rs2 = r2;
    bus.id_rs1_val = d1;  bus.id_rs2_val = d2; bus.id_imm = im;
    bus.id_use_imm = ui;  bus.id_funct = f;    bus.id_rd = rd;
    bus.id_reg_write = rw; bus.id_mem_read = mr;
    bus.id_mem_write = mw; bus.id_branch = br;
  endtask

  task automatic idle();
    drive(1'b0, 3'd0, 3'd0, 16'h0, 16'h0, 16'h0, 1'b0, FUNCT_ADD, 3'd0, 0, 0, 0, 0);
  endtask

  task automatic fwd_src(input logic ew, input logic [2:0] erd, input logic [15:0] eres,
                         input logic mw, input logic [2:0] mrd, input logic [15:0] mres);
    bus.exmem_reg_write = ew; bus.exmem_rd = erd; bus.exmem_result = eres;
    bus.memwb_reg_write = mw; bus.memwb_rd = mrd; bus.memwb_result = mres;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    fwd_src(0, 3'd0, 16'h0, 0, 3'd0, 16'h0);
    drive(1'b1, 3'd1, 3'd2, 16'h1111, 16'h2222, 16'h3333, 1'b0, FUNCT_SUB, 3'd5, 1, 1, 1, 1);
    exp_q.push_back(mk(16'h0, 16'h0, FUNCT_ADD, 16'h0, 16'h0, 1'b0, 3'd0, 0, 0, 0, 0));
    step();
    step();
    exp_o = exp_q.pop_front(); obs = get_obs(); compared++;
    if (obs !== exp_o) begin
      mismatched++; $display("FAIL reset_state got=%h want=%h", obs, exp_o);
    end
    compared++;
    if (bus.load_use_hazard !== 1'b0) begin
      mismatched++; $display("FAIL reset_hazard got=%b want=0", bus.load_use_hazard);
    end
    idle();
    rst_n = 1'b1;
  endtask

  task automatic test_capture();
    drive(1'b1, 3'd1, 3'd2, 16'd5, 16'd7, 16'h0, 1'b0, FUNCT_ADD, 3'd3, 1, 0, 0, 0);
    #1;
    compared++;
    if (bus.load_use_hazard !== 1'b0) begin
      mismatched++; $display("FAIL capture_no_hazard got=%b want=0", bus.load_use_hazard);
    end
    exp_q.push_back(mk(16'd5, 16'd7, FUNCT_ADD, 16'd7, 16'h0, 1'b1, 3'd3, 1, 0, 0, 0));
    step();
    exp_o = exp_q.pop_front(); obs = get_obs(); compared++;
    if (obs !== exp_o) begin
      mismatched++; $display("FAIL capture_add got=%h want=%h", obs, exp_o);
    end
    drive(1'b1, 3'd4, 3'd0, 16'h00A0, 16'h0, 16'h0010, 1'b1, FUNCT_SUB, 3'd5, 1, 0, 0, 0);
    exp_q.push_back(mk(16'h00A0, 16'h0010, FUNCT_SUB, 16'h0, 16'h0010, 1'b1, 3'd5, 1, 0, 0, 0));
    step();
    exp_o = exp_q.pop_front(); obs = get_obs(); compared++;
    if (obs !== exp_o) begin
      mismatched++; $display("FAIL capture_sub_imm got=%h want=%h", obs, exp_o);
    end
    // Invalid slot: data captured, control bits forced low.
    drive(1'b0, 3'd1, 3'd2, 16'h1111, 16'h2222, 16'h0, 1'b0, FUNCT_XOR, 3'd6, 1, 1, 1, 1);
    exp_q.push_back(mk(16'h1111, 16'h2222, FUNCT_XOR, 16'h2222, 16'h0, 1'b0, 3'd6, 0, 0, 0, 0));
    step();
    exp_o = exp_q.pop_front(); obs = get_obs(); compared++;
    if (obs !== exp_o) begin
      mismatched++; $display("FAIL capture_invalid got=%h want=%h", obs, exp_o);
    end
  endtask

  task automatic test_forwarding();
    drive(1'b1, 3'd2, 3'd0, 16'h0001, 16'h0, 16'h0, 1'b0, FUNCT_ADD, 3'd1, 1, 0, 0, 0);
    exp_q.push_back(mk(16'h0001, 16'h0, FUNCT_ADD, 16'h0, 16'h0, 1'b1, 3'd1, 1, 0, 0, 0));
    step();
    exp_o = exp_q.pop_front(); obs = get_obs(); compared++;
    if (obs !== exp_o) begin
      mismatched++; $display("FAIL fwd_setup got=%h want=%h", obs, exp_o);
    end
    idle();
    fwd_src(1, 3'd2, 16'h1234, 1, 3'd2, 16'hBEEF);
    #1;
    compared++;
    if (bus.alu_in1 !== (FWD ? 16'h1234 : 16'h0001)) begin
      mismatched++;
      $display("FAIL fwd_exmem_prio got=%h want=%h", bus.alu_in1, FWD ? 16'h1234 : 16'h0001);
    end
    compared++;
    if (bus.alu_in2 !== 16'h0 || bus.ex_store_data !== 16'h0) begin
      mismatched++;
      $display("FAIL fwd_rs2_r0 got=%h/%h want=0000/0000", bus.alu_in2, bus.ex_store_data);
    end
    bus.exmem_reg_write = 1'b0;
    #1;
    compared++;
    if (bus.alu_in1 !== (FWD ? 16'hBEEF : 16'h0001)) begin
      mismatched++;
      $display("FAIL fwd_memwb got=%h want=%h", bus.alu_in1, FWD ? 16'hBEEF : 16'h0001);
    end
    fwd_src(0, 3'd0, 16'h0, 0, 3'd0, 16'h0);
  endtask

  task automatic test_load_use();
    idle();
    exp_q.push_back(mk(16'h0, 16'h0, FUNCT_ADD, 16'h0, 16'h0, 1'b0, 3'd0, 0, 0, 0, 0));
    step();
    exp_o = exp_q.pop_front(); obs = get_obs(); compared++;
    if (obs !== exp_o) begin
      mismatched++; $display("FAIL lu_idle got=%h want=%h", obs, exp_o);
    end
    drive(1'b1, 3'd1, 3'd0, 16'h0100, 16'h0, 16'h0004, 1'b1, FUNCT_ADD, 3'd3, 1, 1, 0, 0);
    exp_q.push_back(mk(16'h0100, 16'h0004, FUNCT_ADD, 16'h0, 16'h0004, 1'b1, 3'd3, 1, 1, 0, 0));
    step();
    exp_o = exp_q.pop_front(); obs = get_obs(); compared++;
    if (obs !== exp_o) begin
      mismatched++; $display("FAIL lu_load got=%h want=%h", obs, exp_o);
    end
    // rs2 matches the load but operand 2 is the immediate: no hazard.
    drive(1'b1, 3'd0, 3'd3, 16'h0, 16'h0, 16'h0001, 1'b1, FUNCT_ADD, 3'd2, 1, 0, 0, 0);
    #1;
    compared++;
    if (bus.load_use_hazard !== 1'b0) begin
      mismatched++; $display("FAIL lu_rs2_imm got=%b want=0", bus.load_use_hazard);
    end
    drive(1'b1, 3'd3, 3'd2, 16'h0009, 16'h0005, 16'h0, 1'b0, FUNCT_SUB, 3'd4, 1, 0, 0, 0);
    #1;
    compared++;
    if (bus.load_use_hazard !== 1'b1) begin
      mismatched++; $display("FAIL lu_rs1_hazard got=%b want=1", bus.load_use_hazard);
    end
    exp_q.push_back(mk(16'h0, 16'h0, FUNCT_ADD, 16'h0, 16'h0, 1'b0, 3'd0, 0, 0, 0, 0));
    step();
    exp_o = exp_q.pop_front(); obs = get_obs(); compared++;
    if (obs !== exp_o) begin
      mismatched++; $display("FAIL lu_bubble got=%h want=%h", obs, exp_o);
    end
    compared++;
    if (bus.load_use_hazard !== 1'b0) begin
      mismatched++; $display("FAIL lu_hazard_clear got=%b want=0", bus.load_use_hazard);
    end
    exp_q.push_back(mk(16'h0009, 16'h0005, FUNCT_SUB, 16'h0005, 16'h0, 1'b1, 3'd4, 1, 0, 0, 0));
    step();
    exp_o = exp_q.pop_front(); obs = get_obs(); compared++;
    if (obs !== exp_o) begin
      mismatched++; $display("FAIL lu_replay got=%h want=%h", obs, exp_o);
    end
  endtask

  task automatic test_imm_r0();
    fwd_src(1, 3'd0, 16'h5555, 1, 3'd0, 16'h6666);
    drive(1'b1, 3'd5, 3'd0, 16'h0042, 16'h0, 16'hFFFC, 1'b1, FUNCT_ADD, 3'd6, 1, 0, 0, 0);
    #1;
    compared++;
    if (bus.load_use_hazard !== 1'b0) begin
      mismatched++; $display("FAIL r0_no_hazard got=%b want=0", bus.load_use_hazard);
    end
    exp_q.push_back(mk(16'h0042, 16'hFFFC, FUNCT_ADD, 16'h0, 16'hFFFC, 1'b1, 3'd6, 1, 0, 0, 0));
    step();
    exp_o = exp_q.pop_front(); obs = get_obs(); compared++;
    if (obs !== exp_o) begin
      mismatched++; $display("FAIL r0_imm got=%h want=%h", obs, exp_o);
    end
    fwd_src(0, 3'd0, 16'h0, 0, 3'd0, 16'h0);
  endtask

  task automatic test_raw_hazard();
    // EX holds a non-load writing r6; EX/MEM writes r4.
    fwd_src(1, 3'd4, 16'h7777, 0, 3'd0, 16'h0);
    drive(1'b1, 3'd1, 3'd4, 16'h0, 16'h0, 16'h0, 1'b0, FUNCT_ADD, 3'd2, 1, 0, 0, 0);
    #1;
    compared++;
    if (bus.load_use_hazard !== !FWD) begin
      mismatched++; $display("FAIL raw_exmem_rs2 got=%b want=%b", bus.load_use_hazard, !FWD);
    end
    drive(1'b1, 3'd1, 3'd4, 16'h0, 16'h0, 16'h0, 1'b1, FUNCT_ADD, 3'd0, 0, 0, 1, 0);
    #1;
    compared++;
    if (bus.load_use_hazard !== !FWD) begin
      mismatched++; $display("FAIL raw_store_rs2 got=%b want=%b", bus.load_use_hazard, !FWD);
    end
    drive(1'b1, 3'd1, 3'd4, 16'h0, 16'h0, 16'h0, 1'b1, FUNCT_ADD, 3'd2, 1, 0, 0, 0);
    #1;
    compared++;
    if (bus.load_use_hazard !== 1'b0) begin
      mismatched++; $display("FAIL raw_imm_rs2 got=%b want=0", bus.load_use_hazard);
    end
    drive(1'b1, 3'd6, 3'd0, 16'h0, 16'h0, 16'h0, 1'b1, FUNCT_ADD, 3'd2, 1, 0, 0, 0);
    #1;
    compared++;
    if (bus.load_use_hazard !== !FWD) begin
      mismatched++; $display("FAIL raw_ex_rs1 got=%b want=%b", bus.load_use_hazard, !FWD);
    end
    fwd_src(0, 3'd0, 16'h0, 0, 3'd0, 16'h0);
    idle();
  endtask

  task automatic test_stall_flush();
    drive(1'b1, 3'd1, 3'd2, 16'h00F0, 16'h000F, 16'h0, 1'b0, FUNCT_OR, 3'd7, 1, 0, 0, 1);
    exp_q.push_back(mk(16'h00F0, 16'h000F, FUNCT_OR, 16'h000F, 16'h0, 1'b1, 3'd7, 1, 0, 0, 1));
    step();
    exp_o = exp_q.pop_front(); obs = get_obs(); compared++;
    if (obs !== exp_o) begin
      mismatched++; $display("FAIL sf_setup got=%h want=%h", obs, exp_o);
    end
    bus.stall = 1'b1;
    drive(1'b1, 3'd2, 3'd1, 16'hAAAA, 16'h5555, 16'h0, 1'b0, FUNCT_AND, 3'd5, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(mk(16'h00F0, 16'h000F, FUNCT_OR, 16'h000F, 16'h0, 1'b1, 3'd7, 1, 0, 0, 1));
      step();
      exp_o = exp_q.pop_front(); obs = get_obs(); compared++;
      if (obs !== exp_o) begin
        mismatched++; $display("FAIL sf_stall_hold%0d got=%h want=%h", i, obs, exp_o);
      end
    end
    bus.flush = 1'b1;
    bus.id_rs1 = 3'd7;
    #1;
    compared++;
    if (bus.load_use_hazard !== 1'b0) begin
      mismatched++; $display("FAIL sf_flush_mask got=%b want=0", bus.load_use_hazard);
    end
    exp_q.push_back(mk(16'h0, 16'h0, FUNCT_ADD, 16'h0, 16'h0, 1'b0, 3'd0, 0, 0, 0, 0));
    step();
    exp_o = exp_q.pop_front(); obs = get_obs(); compared++;
    if (obs !== exp_o) begin
      mismatched++; $display("FAIL sf_flush_over_stall got=%h want=%h", obs, exp_o);
    end
    bus.flush = 1'b0;
    bus.stall = 1'b0;
    drive(1'b1, 3'd2, 3'd1, 16'hAAAA, 16'h5555, 16'h0, 1'b0, FUNCT_AND, 3'd5, 1, 0, 0, 0);
    exp_q.push_back(mk(16'hAAAA, 16'h5555, FUNCT_AND, 16'h5555, 16'h0, 1'b1, 3'd5, 1, 0, 0, 0));
    step();
    exp_o = exp_q.pop_front(); obs = get_obs(); compared++;
    if (obs !== exp_o) begin
      mismatched++; $display("FAIL sf_resume got=%h want=%h", obs, exp_o);
    end
    // Assert reset between clock edges: outputs must clear without an edge.
    idle();
    #2;
    rst_n = 1'b0;
    exp_q.push_back(mk(16'h0, 16'h0, FUNCT_ADD, 16'h0, 16'h0, 1'b0, 3'd0, 0, 0, 0, 0));
    #1;
    exp_o = exp_q.pop_front(); obs = get_obs(); compared++;
    if (obs !== exp_o) begin
      mismatched++; $display("FAIL sf_async_reset got=%h want=%h", obs, exp_o);
    end
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_back_to_back();
    logic [15:0] v1, v2;
    logic [3:0]  f;
    for (int i = 0; i < 6; i++) begin
      v1 = 16'($urandom_range(0, 65535));
      v2 = 16'($urandom_range(0, 65535));
      f  = (i % 2 == 1) ? FUNCT_SUB : FUNCT_XOR;
      drive(1'b1, 3'(1 + i % 3), 3'(4 + i % 3), v1, v2, 16'h0, 1'b0, f, 3'd7, 1, 0, 0, 0);
      exp_q.push_back(mk(v1, v2, f, v2, 16'h0, 1'b1, 3'd7, 1, 0, 0, 0));
      step();
      exp_o = exp_q.pop_front(); obs = get_obs(); compared++;
      if (obs !== exp_o) begin
        mismatched++; $display("FAIL b2b_%0d got=%h want=%h", i, obs, exp_o);
      end
    end
    idle();
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    test_reset();
    test_capture();
    test_forwarding();
    test_load_use();
    test_imm_r0();
    test_raw_hazard();
    test_stall_flush();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register and operand-select stage that sits directly upstream of the 16-bit ALU.
- Captures decoded fields each cycle and handles stall, flush and load-use bubble insertion.
- Resolves EX/MEM and MEM/WB forwarding, then drives ALU in1/in2/op plus the control bundle for the EX/MEM register.
- Architecture: 8 registers (3-bit index); r0 is hardwired to zero.

Parameters:
- DW, 16, datapath width.
- RW, 3, register index width.

Ports:
- clk  in  1  stage clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  decode slot holds a real instruction.
- id_rs1, id_rs2  in  RW  source register indices.
- id_rs1_val, id_rs2_val  in  DW  register-file read data.
- id_imm  in  DW  sign-extended immediate.
- id_use_imm  in  1  ALU operand 2 is the immediate.
- id_funct  in  4  ALU funct code (shared FUNCT_* values).
- id_rd  in  RW  destination index.
- id_reg_write, id_mem_read, id_mem_write, id_branch  in  1 each  control bits.
- stall  in  1  hold all stage contents.
- flush  in  1  replace next contents with a bubble.
- exmem_reg_write  in  1  EX/MEM instruction writes a register.
- exmem_rd  in  RW  EX/MEM destination.
- exmem_result  in  DW  EX/MEM result.
- memwb_reg_write  in  1  MEM/WB instruction writes a register.
- memwb_rd  in  RW  MEM/WB destination.
- memwb_result  in  DW  MEM/WB writeback value.
- alu_in1, alu_in2  out  DW  ALU operands.
- alu_op  out  4  ALU funct code.
- ex_store_data  out  DW  forwarded rs2 value for stores.
- ex_valid, ex_rd, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_imm  out  registered bundle toward EX/MEM.
- load_use_hazard  out  1  combinational; decode must hold.

Behaviour:
- Registered state: valid, rs1/rs2 indices and values, imm, use_imm, funct, rd, the four control bits, and a uses_rs2 flag.
- uses_rs2 = !id_use_imm | id_mem_write.
- Reset (async, rst_n=0):
  - All registered fields clear to 0; funct resets to FUNCT_ADD.
  - Resulting outputs: ex_valid=0, all control bits 0, alu_in1=alu_in2=0, ex_store_data=0, alu_op=FUNCT_ADD, load_use_hazard=0.
- Per-posedge update priority, highest first:
  1. flush: load a bubble (valid and controls 0, data 0, funct FUNCT_ADD).
  2. stall: hold all registers.
  3. load_use_hazard: load a bubble.
  4. Otherwise capture the id_* inputs. If id_valid=0, the control bits are forced to 0.
- flush and stall in the same cycle: flush wins.
- Latency: one cycle from id_* to the ex_* and alu_* outputs.
- Forwarding is combinational on the registered rs1/rs2 values. Per operand:
  - If the index is nonzero and exmem_reg_write is set with exmem_rd equal to it, use exmem_result.
  - Else if the same holds for memwb_reg_write/memwb_rd, use memwb_result.
  - Else use the registered value.
  - EX/MEM takes priority over MEM/WB.
  - Index 0 never forwards; a register index 0 operand reads as 0.
- Operand 2 path: ex_store_data = forwarded rs2. alu_in2 = ex_imm if use_imm, else forwarded rs2.
- alu_in1 = forwarded rs1.
- alu_op = registered funct.
- load_use_hazard is asserted when all of the following hold:
  - ex_valid & ex_mem_read
  - ex_rd != 0
  - id_valid
  - ex_rd == id_rs1, or ex_rd == id_rs2 with id uses_rs2
- load_use_hazard is masked to 0 while flush=1.
- Arithmetic: no width changes; all values are DW bits, passed unchanged.

Optional Feature:
- Macro: PIPE_FORWARD_EN.
- Defined: forwarding as described above.
- Undefined:
  - alu_in1, alu_in2 and ex_store_data use the registered values only; the exmem_* and memwb_* inputs are ignored.
  - load_use_hazard becomes a general RAW hazard. It asserts when the decode source (rs1, or rs2 with uses_rs2) is nonzero and matches either:
    - ex_rd with ex_valid & ex_reg_write, or
    - exmem_rd with exmem_reg_write.
  - The register file is write-before-read, so MEM/WB needs no check.

Decomposition:
- Shared header pipeline_defs.vh:
  - Register index width.
  - Bubble funct (FUNCT_ADD, taken from the existing funct header).
  - Reset/bubble data value 0.
- Sub-module fwd_mux, instantiated twice (rs1 and rs2):
  - Inputs: index, registered value, both forward sources.
  - Output: the selected value.

Test Plan:
- Reset and capture: reset, then capture id ADD, rs1_val=5, rs2_val=7, no hazard → next cycle alu_in1=5, alu_in2=7, alu_op=FUNCT_ADD, ex_valid=1.
- EX/MEM forwarding: EX holds rs1=2; exmem_reg_write=1, exmem_rd=2, exmem_result=0x1234; memwb_rd=2, memwb_result=0xBEEF → alu_in1=0x1234 (EX/MEM priority); with exmem_reg_write=0, alu_in1=0xBEEF.
- Load-use bubble: EX holds a load with rd=3; decode rs1=3 → load_use_hazard=1; next cycle ex_valid=0, ex_reg_write=0, alu_op=FUNCT_ADD.
- Immediate and r0: decode rs2=0 with use_imm=1, imm=0xFFFC; exmem_rd=0 with exmem_reg_write=1 → alu_in2=0xFFFC, ex_store_data=0, no forwarding.
- Stall, flush, async reset: stall=1 for 3 cycles → outputs held; stall=1 & flush=1 → bubble; rst_n asserted mid-cycle → outputs clear immediately, without waiting for a clock edge.
- PIPE_FORWARD_EN undefined: exmem_rd=4, exmem_reg_write=1, decode rs2=4, use_imm=0 → load_use_hazard=1.
